// File: rtl/dac_sample_sched_if.sv
// Port-decoder/DMA side <-> DAC sample scheduler bundle.
// The master drives writes and controls; the slave returns the DAC value and FIFO status.
interface dac_sample_sched_if #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 12
);
    logic [7:0]              din;
    logic                    fifo_wr;
    logic                    covox_wr;
    logic                    beeper_wr;
    logic                    beeper_mux;
    logic                    cfg_wr;
    logic [DIV_W-1:0]        cfg_div;
    logic                    play_en;
    logic                    underrun_clr;
    logic [7:0]              dac_val;
    logic                    dac_strobe;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    dreq;
    logic                    underrun;
    logic                    overflow;

    modport master (
        output din, fifo_wr, covox_wr, beeper_wr, beeper_mux, cfg_wr, cfg_div,
               play_en, underrun_clr,
        input  dac_val, dac_strobe, fifo_level, fifo_full, fifo_empty, dreq,
               underrun, overflow
    );

    modport slave (
        input  din, fifo_wr, covox_wr, beeper_wr, beeper_mux, cfg_wr, cfg_div,
               play_en, underrun_clr,
        output dac_val, dac_strobe, fifo_level, fifo_full, fifo_empty, dreq,
               underrun, overflow
    );
endinterface

// File: rtl/dac_sample_sched.sv
// Covox/beeper DAC sample scheduler: direct port writes in IDLE, FIFO playback
// paced by a programmable down-counter divider in PLAY.
//
// state | meaning
// IDLE  | direct covox/beeper writes drive the DAC value
// PRIME | playback requested, waiting for the FIFO to reach half full
// PLAY  | divider ticks pop FIFO samples into the DAC value
module dac_sample_sched #(
    parameter int DEPTH   = 16,
    parameter int DIV_W   = 12,
    parameter int DIV_RST = 634
) (
    input logic              clk,
    input logic              reset,
    dac_sample_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t          state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [7:0]      dac_val;
    logic            dac_strobe;
    logic            underrun;
    logic            overflow;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            full;
    logic            empty;
    logic            tick;
    logic            pop;
    logic            push;
    logic            beep_bit;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign tick     = (state == PLAY) && (cnt == '0);
    assign pop      = tick && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = bus.fifo_wr && (!full || pop);
    assign beep_bit = bus.beeper_mux ? bus.din[3] : bus.din[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div        <= DIV_W'(DIV_RST);
            cnt        <= DIV_W'(DIV_RST);
            dac_val    <= 8'h00;
            dac_strobe <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dac_strobe <= 1'b0;
            if (bus.cfg_wr)
                div <= bus.cfg_div;

            case (state)
                IDLE: begin
                    if (bus.covox_wr) begin
                        dac_val    <= bus.din;
                        dac_strobe <= 1'b1;
                    end else if (bus.beeper_wr) begin
                        dac_val    <= beep_bit ? 8'hFF : 8'h00;
                        dac_strobe <= 1'b1;
                    end
                    if (bus.play_en)
                        state <= PRIME;
                end
                PRIME: begin
                    if (!bus.play_en) begin
                        state <= IDLE;
                    end else if (level >= LW'(DEPTH / 2)) begin
                        state <= PLAY;
                        cnt   <= div;
                    end
                end
                PLAY: begin
                    if (!bus.play_en)
                        state <= IDLE;
                    // cfg_wr only lands here, so a new period starts at the next reload.
                    if (cnt == '0)
                        cnt <= div;
                    else
                        cnt <= cnt - DIV_W'(1);
                    if (pop) begin
                        dac_val    <= mem[rd_ptr];
                        dac_strobe <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.underrun_clr) begin
                underrun <= 1'b0;
                overflow <= 1'b0;
            end
            if (tick && empty)
                underrun <= 1'b1;
            if (bus.fifo_wr && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sample storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.din;
    end

    assign bus.dac_val    = dac_val;
    assign bus.dac_strobe = dac_strobe;
    assign bus.fifo_level = level;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.dreq       = (state != IDLE) && (level < LW'(DEPTH / 2));
    assign bus.underrun   = underrun;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_dac_sample_sched.sv
// Bench for dac_sample_sched: expected DAC values are queued as stimulus is
// issued; a forked monitor pops and compares on every dac_strobe.
module tb_dac_sample_sched;
    logic clk = 1'b0;
    logic reset;

    dac_sample_sched_if #(.DEPTH(16), .DIV_W(12)) bus ();

    dac_sample_sched #(.DEPTH(16), .DIV_W(12), .DIV_RST(634)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int last_s = 0;
    int prev_s = 0;
    int s0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.dac_strobe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got dac_val 0x%0h with nothing expected", bus.dac_val);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dac_val !== e) begin
                        errors++;
                        $display("FAIL dac_val: got 0x%0h expected 0x%0h", bus.dac_val, e);
                    end
                end
                prev_s = last_s;
                last_s = cyc_n;
                strobe_cnt++;
            end
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget && strobe_cnt < target; i++)
            tick_clk();
        if (strobe_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got %0d strobes expected %0d", strobe_cnt, target);
        end
    endtask

    task automatic direct(input logic cov, input logic beep, input logic mux,
                          input logic [7:0] d, input logic expect_it, input logic [7:0] ev);
        bus.covox_wr   = cov;
        bus.beeper_wr  = beep;
        bus.beeper_mux = mux;
        bus.din        = d;
        if (expect_it) exp_q.push_back(ev);
        tick_clk();
        bus.covox_wr  = 1'b0;
        bus.beeper_wr = 1'b0;
    endtask

    task automatic cfg(input logic [11:0] v);
        bus.cfg_wr  = 1'b1;
        bus.cfg_div = v;
        tick_clk();
        bus.cfg_wr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic expect_it);
        bus.fifo_wr = 1'b1;
        bus.din     = d;
        if (expect_it) exp_q.push_back(d);
        tick_clk();
        bus.fifo_wr = 1'b0;
    endtask

    initial begin
        bus.din = 8'h00; bus.fifo_wr = 0; bus.covox_wr = 0; bus.beeper_wr = 0;
        bus.beeper_mux = 0; bus.cfg_wr = 0; bus.cfg_div = 12'd0; bus.play_en = 0;
        bus.underrun_clr = 0;
        reset = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick_clk();
        reset = 1'b0;

        chk("rst_dac_val", 32'(bus.dac_val), 32'h00);
        chk("rst_strobe", 32'(bus.dac_strobe), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_dreq", 32'(bus.dreq), 32'd0);

        // Direct writes in IDLE
        direct(1, 0, 0, 8'h5A, 1, 8'h5A);
        direct(0, 1, 0, 8'h10, 1, 8'hFF);
        direct(0, 1, 0, 8'h08, 1, 8'h00);
        direct(0, 1, 1, 8'h08, 1, 8'hFF);
        direct(1, 1, 0, 8'h10, 1, 8'h10);
        direct(1, 0, 0, 8'h10, 1, 8'h10);
        repeat (2) tick_clk();
        chk("direct_final", 32'(bus.dac_val), 32'h10);

        // Paced playback, DIV=3
        cfg(12'd3);
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
        chk("level_8", 32'(bus.fifo_level), 32'd8);
        chk("idle_dreq", 32'(bus.dreq), 32'd0);
        bus.play_en = 1'b1;
        s0 = strobe_cnt;
        wait_strobes(s0 + 2, 40);
        chk("play_dreq", 32'(bus.dreq), 32'd1);
        chk("period_div3", 32'(last_s - prev_s), 32'd4);
        direct(1, 0, 0, 8'h33, 0, 8'h00);
        wait_strobes(s0 + 8, 60);
        chk("period_div3_last", 32'(last_s - prev_s), 32'd4);
        repeat (6) tick_clk();
        chk("underrun_set", 32'(bus.underrun), 32'd1);
        chk("underrun_hold", 32'(bus.dac_val), 32'h08);
        chk("underrun_empty", 32'(bus.fifo_empty), 32'd1);
        bus.play_en = 1'b0;
        repeat (2) tick_clk();
        bus.underrun_clr = 1'b1;
        tick_clk();
        bus.underrun_clr = 1'b0;
        chk("underrun_clr", 32'(bus.underrun), 32'd0);

        // Overflow and push-while-full with a simultaneous pop
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
        chk("full_level", 32'(bus.fifo_level), 32'd16);
        chk("full_flag", 32'(bus.fifo_full), 32'd1);
        push(8'hEE, 1'b0);
        chk("overflow_set", 32'(bus.overflow), 32'd1);
        chk("overflow_level", 32'(bus.fifo_level), 32'd16);
        cfg(12'd0);
        s0 = strobe_cnt;
        bus.play_en = 1'b1;
        tick_clk();
        tick_clk();
        push(8'hA5, 1'b1);
        chk("push_pop_full_level", 32'(bus.fifo_level), 32'd16);
        wait_strobes(s0 + 17, 60);
        chk("period_div0", 32'(last_s - prev_s), 32'd1);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);
        bus.play_en = 1'b0;
        repeat (2) tick_clk();
        bus.underrun_clr = 1'b1;
        tick_clk();
        bus.underrun_clr = 1'b0;
        chk("overflow_clr", 32'(bus.overflow), 32'd0);

        // Divider change mid-period, covox ignored during PLAY
        cfg(12'd3);
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i), 1'b1);
        s0 = strobe_cnt;
        bus.play_en = 1'b1;
        wait_strobes(s0 + 1, 40);
        cfg(12'd7);
        wait_strobes(s0 + 2, 40);
        chk("period_before_cfg", 32'(last_s - prev_s), 32'd4);
        chk("play_dreq2", 32'(bus.dreq), 32'd1);
        direct(1, 0, 0, 8'h33, 0, 8'h00);
        wait_strobes(s0 + 3, 40);
        chk("period_after_cfg", 32'(last_s - prev_s), 32'd8);
        bus.play_en = 1'b0;
        repeat (3) tick_clk();
        chk("idle_hold", 32'(bus.dac_val), 32'h23);
        chk("idle_level", 32'(bus.fifo_level), 32'd5);

        // Reset mid-PLAY with 5 samples queued
        for (int i = 0; i < 3; i++) push(8'(8'h29 + i), 1'b1);
        s0 = strobe_cnt;
        bus.play_en = 1'b1;
        wait_strobes(s0 + 3, 60);
        chk("pre_reset_level", 32'(bus.fifo_level), 32'd5);
        reset = 1'b1;
        tick_clk();
        chk("mid_rst_dac_val", 32'(bus.dac_val), 32'h00);
        chk("mid_rst_strobe", 32'(bus.dac_strobe), 32'd0);
        chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        chk("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("mid_rst_dreq", 32'(bus.dreq), 32'd0);
        chk("mid_rst_underrun", 32'(bus.underrun), 32'd0);
        bus.play_en = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        s0 = strobe_cnt;
        direct(1, 0, 0, 8'h77, 1, 8'h77);
        wait_strobes(s0 + 1, 10);
        repeat (2) tick_clk();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample scheduler for the covox/beeper DAC path. It owns the 8-bit value that feeds the sigma-delta/PWM modulator and arbitrates between direct CPU port writes (covox, beeper) and timed FIFO playback. Playback runs at a programmable sample rate derived from `clk`, with priming, underrun/overflow flags and a refill request. It sits between the port decoder/DMA and the modulator's `val` input.

## Interface
Parameters:
- `DEPTH`, 16, sample FIFO depth in bytes; power of two, ≥4.
- `DIV_W`, 12, width of the sample-period divider.
- `DIV_RST`, 634, divider reset value; period is DIV+1 clk cycles, about 44.1 kHz at 28 MHz.

Ports:
- `clk` in 1: system clock, 28 MHz.
- `reset` in 1: synchronous, active-high.
- `din` in 8: CPU/DMA write data.
- `fifo_wr` in 1: push `din` into the FIFO.
- `covox_wr` in 1: direct DAC write.
- `beeper_wr` in 1: beeper port write.
- `beeper_mux` in 1: 1 selects `din[3]` (tape out), 0 selects `din[4]` (beeper).
- `cfg_wr` in 1: load `cfg_div` into the DIV register.
- `cfg_div` in DIV_W: new divider value.
- `play_en` in 1: level input; 1 requests timed playback.
- `underrun_clr` in 1: clears `underrun` and `overflow`.
- `dac_val` out 8: value to the modulator.
- `dac_strobe` out 1: one-cycle pulse in the cycle `dac_val` takes a new value.
- `fifo_level` out log2(DEPTH)+1: current FIFO occupancy.
- `fifo_full` out 1: `fifo_level` == DEPTH.
- `fifo_empty` out 1: `fifo_level` == 0.
- `dreq` out 1: refill request, `state` != IDLE && `fifo_level` < DEPTH/2.
- `underrun` out 1: sticky; a tick found the FIFO empty.
- `overflow` out 1: sticky; a push was attempted while full.

## Operation
- FSM states:
  - IDLE → PRIME when `play_en`=1.
  - PRIME → PLAY when `play_en`=1 and `fifo_level` ≥ DEPTH/2. Divider counter loads DIV on entry to PLAY.
  - PRIME → IDLE when `play_en`=0.
  - PLAY → IDLE when `play_en`=0. The IDLE transition has priority over all other transitions.
- IDLE:
  - `covox_wr`: `dac_val` ← `din`.
  - Otherwise `beeper_wr`: `dac_val` ← bit ? 8'hFF : 8'h00, where bit is `din[3]` or `din[4]` per `beeper_mux`.
  - `covox_wr` has priority over `beeper_wr` in the same cycle.
- PRIME/PLAY: `covox_wr` and `beeper_wr` are ignored and `dac_val` is unchanged by them.
- Divider in PLAY:
  - Counter decrements each cycle. At 0 it asserts an internal tick and reloads DIV, giving a period of DIV+1 cycles.
  - A `cfg_wr` takes effect at the next reload, not mid-period.
  - DIV=0 gives a tick every cycle.
- Tick with FIFO non-empty: pop the head into `dac_val` and pulse `dac_strobe`.
- Tick with FIFO empty: `dac_val` holds, no strobe, `underrun` ← 1, state stays PLAY.
- FIFO:
  - Circular, with read/write pointers wrapping at DEPTH.
  - Push while full is dropped and sets `overflow` ← 1.
  - Push and pop in the same cycle: both occur, level unchanged. When full, the pop frees the slot and the push is accepted.
- Leaving PLAY/PRIME does not flush the FIFO. `dac_val` keeps its last value.
- `underrun_clr` in the same cycle as a set event: the set wins.
- `dac_strobe` also pulses on IDLE `covox_wr`/`beeper_wr` updates, even when the value is unchanged.

## Timing
- Reset values:
  - `dac_val`=0x00, `dac_strobe`=0.
  - FIFO empty, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0.
  - `underrun`=0, `overflow`=0, `dreq`=0.
  - State IDLE, DIV=DIV_RST.
- `reset` mid-playback returns everything to reset values on the next edge. FIFO contents are discarded.
- Direct write in cycle N: `dac_val` and `dac_strobe` are valid in N+1.
- Tick in cycle N: popped `dac_val` and `dac_strobe` are valid in N+1.
- `fifo_level`, `fifo_full`, `fifo_empty` reflect a push or pop one cycle after the request.
- `dreq` is combinational from state and level.
- PRIME→PLAY: the first tick occurs DIV+1 cycles after the cycle PLAY is entered.

## Test plan
- Reset, then IDLE `covox_wr` with `din`=0x5A → `dac_val`=0x5A and `dac_strobe`=1 next cycle. Then `beeper_wr` with `beeper_mux`=0 and `din`=0x10 → 0xFF; with `din`=0x08 → 0x00. Then `beeper_mux`=1 with `din`=0x08 → 0xFF.
- DIV=3, push 8 samples 0x01..0x08 at DEPTH=16, `play_en`=1 → PRIME then PLAY; `dac_val` steps 0x01, 0x02, … every 4 cycles; `dreq`=1 throughout.
- DIV=3, push 8 samples, play; after 8 ticks the FIFO is empty → `underrun`=1 and `dac_val` holds 0x08. `underrun_clr` → 0.
- Fill 16 samples, push a 17th 0xEE → dropped, `overflow`=1, `fifo_level`=16. Simultaneous push and tick-pop when full → level stays 16 and the new sample is accepted.
- `covox_wr` 0x33 during PLAY → ignored. `play_en`=0 → IDLE with `dac_val` held. `cfg_wr` DIV=7 mid-period → the current period completes, then 8-cycle periods follow.
- `reset` asserted mid-PLAY with 5 samples queued → next cycle all outputs are at reset values and `fifo_level`=0.
